// File: rtl/core_exu_div_ctrl.sv
`timescale 1ns/1ps
// Purpose: EX-stage issue/retire controller for the iterative divider.
// Latency: start pulse 1 cycle after accept. The writeback comes 1 cycle after div_vld_i.
// Backpressure: stall_o holds IF/ID/EX while a divide is outstanding, and flushed results are drained silently.
module core_exu_div_ctrl #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        dec_vld_i,
  input  logic [2:0]  dec_funct3_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  input  logic        div_hold_i,
  input  logic        div_vld_i,
  input  logic [31:0] div_data_i,
  output logic [31:0] div_data1_o,
  output logic [31:0] div_data2_o,
  output logic [4:0]  div_waddr_o,
  output logic        div_op_o,
  output logic        div_q_sign_o,
  output logic        div_r_sign_o,
  output logic        div_start_o,
  output logic        stall_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_waddr_o,
  output logic [31:0] wb_data_o,
  output logic        err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   data1_q, data1_d;
  logic [31:0]   data2_q, data2_d;
  logic [4:0]    rd_q, rd_d;
  logic          op_q, op_d;
  logic          q_sign_q, q_sign_d;
  logic          r_sign_q, r_sign_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [CW-1:0] wdog_q, wdog_d;

  logic is_signed;
  logic accept;

  // funct3[2] is always 1 for this class, and the divider hold is only observed, never acted on.
  logic unused_ok;
  assign unused_ok = ^{dec_funct3_i[2], div_hold_i};

  // Two's-complement magnitude with 32-bit wrap, so the most negative value maps to itself.
  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  assign is_signed = ~dec_funct3_i[0];
  assign accept    = dec_vld_i & ~flush_i & (rd_addr_i != 5'd0);

  // Next-state, operand latch, watchdog and the per-state strobes.
  always_comb begin
    state_d     = state_q;
    data1_d     = data1_q;
    data2_d     = data2_q;
    rd_d        = rd_q;
    op_d        = op_q;
    q_sign_d    = q_sign_q;
    r_sign_d    = r_sign_q;
    wb_data_d   = wb_data_q;
    wdog_d      = wdog_q;
    div_start_o = 1'b0;
    stall_o     = 1'b0;
    wb_we_o     = 1'b0;
    err_o       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        stall_o = accept;
        if (accept) begin
          data1_d  = is_signed ? mag(rs1_data_i) : rs1_data_i;
          data2_d  = is_signed ? mag(rs2_data_i) : rs2_data_i;
          rd_d     = rd_addr_i;
          op_d     = ~dec_funct3_i[1];
          // Divide-by-zero keeps the all-ones quotient unsigned.
          q_sign_d = is_signed & (rs1_data_i[31] ^ rs2_data_i[31]) & (rs2_data_i != 32'd0);
          r_sign_d = is_signed & rs1_data_i[31];
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_start_o = 1'b1;
        stall_o     = ~flush_i;
        wdog_d      = '0;
        state_d     = flush_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        stall_o = ~flush_i;
        if (div_vld_i) begin
          // Flush wins: a result arriving with a flush is simply dropped.
          if (!flush_i) begin
            wb_data_d = div_data_i;
            state_d   = S_WB;
          end else begin
            state_d   = S_IDLE;
          end
        end else if (flush_i) begin
          wdog_d  = '0;
          state_d = S_DRAIN;
        end else if (wdog_q == WD_LAST) begin
          err_o   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d  = wdog_q + CW'(1);
        end
      end
      S_WB: begin
        wb_we_o = ~flush_i;
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        // The divider cannot be aborted. Any new divide is held off until the killed one finishes.
        stall_o = dec_vld_i;
        if (div_vld_i) begin
          state_d = S_IDLE;
        end else if (wdog_q == WD_LAST) begin
          err_o   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d  = wdog_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      data1_q   <= '0;
      data2_q   <= '0;
      rd_q      <= '0;
      op_q      <= 1'b0;
      q_sign_q  <= 1'b0;
      r_sign_q  <= 1'b0;
      wb_data_q <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      rd_q      <= rd_d;
      op_q      <= op_d;
      q_sign_q  <= q_sign_d;
      r_sign_q  <= r_sign_d;
      wb_data_q <= wb_data_d;
      wdog_q    <= wdog_d;
    end
  end

  assign div_data1_o  = data1_q;
  assign div_data2_o  = data2_q;
  assign div_waddr_o  = rd_q;
  assign div_op_o     = op_q;
  assign div_q_sign_o = q_sign_q;
  assign div_r_sign_o = r_sign_q;
  assign wb_waddr_o   = rd_q;
  assign wb_data_o    = wb_data_q;

endmodule
